seq_decoder: RTL

Parametrised, registered binary-to-one-hot decoder with valid/ready handshakes on both sides. Generalises the fixed 3-to-8 gate-level decoder to N select bits and 2^N outputs, and adds a scan mode that emits one one-hot beat per output line from line 0 up to the requested index. It sits between a command source, such as a sequencer or CPU register, and select-line consumers, such as chip-select, LED/row scanning or demux enables, that need back-pressure.

---
 rtl/seq_decoder.sv | 112 +++++++++++
 1 files changed

// File: rtl/seq_decoder.sv
// seq_decoder
// Registered binary-to-one-hot decoder with valid/ready handshakes on both
// sides. A single-mode command emits one beat on line in_sel. A scan-mode
// command emits one beat per line, from line 0 up to line in_sel.
//
// Build option: define SEQ_DECODER_ACTIVE_LOW_EN to make out_d one-cold.
// In that build the idle and reset value is all ones, and the handshake is
// unchanged.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   command present
//   in_ready   command can be accepted this cycle (combinational)
//   in_sel     target line index (N bits)
//   in_mode    0 = single beat, 1 = scan 0..in_sel
//   out_valid  out_d holds a valid beat
//   out_ready  consumer takes the beat this cycle
//   out_d      decoded lines (2^N bits), driven from registers only
//   out_last   current beat is the final beat of its command
//   busy       a command is in progress (same as out_valid)
//
// state  | meaning
// -------+------------------------------------------------
// IDLE   | no beat pending, out_d at its idle value
// SINGLE | one beat pending on line idx, always last
// SCAN   | walking idx from 0 up to tgt, last when idx == tgt
module seq_decoder #(
    parameter int N = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N-1:0]       in_sel,
    input  logic               in_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [(1<<N)-1:0]  out_d,
    output logic               out_last,
    output logic               busy
);

    localparam int W = 1 << N;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SINGLE = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t         state, state_nxt;
    logic [N-1:0]   idx, idx_nxt;
    logic [N-1:0]   tgt, tgt_nxt;
    logic           scan;
    logic           last;
    logic           accept;
    logic           fire;
    logic [W-1:0]   onehot;

    assign scan      = (state == SCAN);
    assign out_valid = (state != IDLE);
    assign busy      = out_valid;
    assign last      = !scan || (idx == tgt);
    assign out_last  = out_valid && last;

    // A new command may load on the same edge that retires the final beat,
    // so back-to-back commands need no idle cycle between them.
    assign in_ready  = !out_valid || (out_ready && last);
    assign accept    = in_valid && in_ready;
    assign fire      = out_valid && out_ready;

    assign onehot = {{(W-1){1'b0}}, 1'b1} << idx;

`ifdef SEQ_DECODER_ACTIVE_LOW_EN
    assign out_d = out_valid ? ~onehot : {W{1'b1}};
`else
    assign out_d = out_valid ? onehot : {W{1'b0}};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            tgt   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            tgt   <= tgt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        tgt_nxt   = tgt;
        // accept implies any pending beat is last and firing, so the
        // accept branch also covers the fire-with-last-and-accept case.
        if (accept) begin
            tgt_nxt   = in_sel;
            idx_nxt   = in_mode ? '0 : in_sel;
            state_nxt = in_mode ? SCAN : SINGLE;
        end else if (fire) begin
            if (!last) begin
                idx_nxt = idx + N'(1);
            end else begin
                state_nxt = IDLE;
            end
        end
    end

endmodule
